pc_reg_fetch: RTL and testbench
===============================

# pc_reg_fetch

Program-counter stage at the head of the pipeline. Generates the fetch address and instruction-ROM enable each cycle, and feeds `if_pc` into the IF/ID register. It arbitrates among the following next-PC sources:
- sequential increment;
- the IF/ID-stage static branch prediction;
- EX-stage resolved branches;
- trap/flush redirects.

Redirects that arrive while the PC is frozen are captured and replayed, so none is lost under stall or bus back-pressure.

## Interface
- Parameters:
  - `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- Ports:
  - `clk` in 1: single clock; all state updates on the rising edge.
  - `rst` in 1: reset, synchronous and active-high.
  - `stall` in 6: pipeline stall vector; bit 0 freezes the PC.
  - `flush` in 1: trap/exception flush.
  - `new_pc` in 32: flush target.
  - `branch_flag_i` in 1: EX resolved redirect, covering mispredicts and JALR.
  - `branch_target_address_i` in 32: EX redirect target.
  - `branch_flag_pred` in 1: IF/ID prediction valid.
  - `branch_tar_addr_pred` in 32: predicted target.
  - `inst_ready_i` in 1: instruction ROM accepted the current fetch.
  - `pc` out 32: fetch address, registered.
  - `ce` out 1: ROM chip enable, registered.
  - `stallreq_if_o` out 1: asks the stall controller to freeze; combinational, `ce & ~inst_ready_i`.

## Operation
- FSM states:
  - `S_RST`: `ce`=0, `pc`=`RESET_PC`. Always entered while `rst`=1. Exits to `S_RUN` on the first cycle with `rst`=0.
  - `S_RUN`: `ce`=1. Moves to `S_WAIT` when `inst_ready_i`=0.
  - `S_WAIT`: `ce`=1, `pc` held. Returns to `S_RUN` in the cycle `inst_ready_i`=1.
- Advance condition: `adv = (state==S_RUN|S_WAIT) & inst_ready_i & ~stall[0]`.
- Next-PC priority, highest first:
  1. `rst`: `pc`=`RESET_PC`, `ce`=0, pending cleared.
  2. `flush`: `pc`=`new_pc`. Applied even when `adv`=0. Clears pending.
  3. `branch_flag_i`:
     - if `adv`=1: `pc`=`branch_target_address_i`;
     - otherwise the target is latched into the pending register (`pend_valid`=1, `pend_addr`). A newer EX redirect overwrites an older pending one.
  4. `pend_valid` and `adv`=1: `pc`=`pend_addr`; `pend_valid` cleared.
  5. `branch_flag_pred` and `adv`=1 and no pending redirect: `pc`=`branch_tar_addr_pred`.
  6. `adv`=1: `pc`=`pc`+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  7. Otherwise `pc` is held.
- Alignment: every value loaded into `pc` has bits [1:0] forced to 2'b00.
- A prediction presented while `adv`=0 is dropped, not latched. IF/ID re-presents it when it un-stalls.
- Reset values: `pc`=`RESET_PC`, `ce`=0, `stallreq_if_o`=0, `pend_valid`=0, `pend_addr`=0, state `S_RST`.

## Timing
- All `pc` and `ce` updates are visible one cycle after the deciding edge. A redirect sampled at edge N appears on `pc` after edge N.
- After `rst` is released, `ce` rises one cycle later with `pc`=`RESET_PC`. The first increment happens on the following advancing cycle.
- A pending redirect is applied on the first edge where `adv`=1. Latency is stall length + 1 cycle.
- Simultaneous `flush` and `branch_flag_i`: flush wins and the EX target is discarded.
- Simultaneous `branch_flag_i` and `branch_flag_pred`: EX wins.
- `rst` asserted mid-stall or mid-`S_WAIT`: state returns to `S_RST` on that edge and pending is cleared.
- `stallreq_if_o` is combinational from registered `ce` and input `inst_ready_i`. It has no path from `stall`, so there is no loop.

## Configuration
- `BRANCH_PRED_EN` defined: priority level 5 is active, and predicted targets redirect the fetch.
- `BRANCH_PRED_EN` undefined:
  - `branch_flag_pred` and `branch_tar_addr_pred` are ignored and their logic is compiled out;
  - every branch flows sequentially and is corrected by EX via `branch_flag_i`.
- Ports remain present in both builds.

## Structure
- `define.v` supplies `InstAddrBus`, `ZeroWord`, `RstEnable`, `Stop`/`NoStop`, `ChipEnable`/`ChipDisable`.
- Add the following to `define.v`:
  - the state encodings `S_RST`/`S_RUN`/`S_WAIT`;
  - `PcIncr` (32'd4).
- One sub-module, `pc_next_sel`: the purely combinational priority mux for levels 2–7, producing `next_pc`, `load_pend` and `clear_pend`. The top level holds the FSM, the `pc`/`ce` registers and the pending register.

## Test plan
- Reset then run, `inst_ready_i`=1, no stalls: `ce`=0 for 1 cycle after release, then `pc` = 0, 4, 8, 12 on consecutive cycles.
- `stall[0]`=1 for 3 cycles with `pc`=0x10, and `branch_flag_i` pulsed on the 2nd cycle (target 0x200): `pc` holds 0x10, then becomes 0x200 on the first un-stalled edge, then 0x204.
- Under `BRANCH_PRED_EN`, `branch_flag_pred`=1 with target 0x40 and `pc`=0x20: `pc` becomes 0x40. The same stimulus with the macro undefined gives `pc`=0x24.
- `flush`=1 (`new_pc`=0x80) together with `branch_flag_i`=1 (0x300) during `stall[0]`=1: `pc`=0x80 next cycle, pending cleared, no later jump to 0x300.
- `inst_ready_i`=0 for 2 cycles at `pc`=0x8: `stallreq_if_o`=1 for both cycles, `pc` held at 0x8, then 0xC after ready.
- `pc`=32'hFFFF_FFFC advancing: `pc` becomes 0x0. A misaligned target 0x103 loads as 0x100.

Source files
------------

// File: rtl/pc_reg_fetch_pkg.sv
// Shared types and constants for the PC / fetch-address stage.
package pc_reg_fetch_pkg;

    typedef logic [31:0] inst_addr_t;

    localparam inst_addr_t ZeroWord = 32'h0000_0000;
    localparam inst_addr_t PcIncr   = 32'd4;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    function automatic inst_addr_t align_pc(input inst_addr_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: flush, EX redirect, pending replay,
// prediction (only when BRANCH_PRED_EN is defined), increment, hold.
module pc_next_sel
    import pc_reg_fetch_pkg::*;
(
    input  inst_addr_t pc,
    input  logic       adv,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag,
    input  inst_addr_t branch_target,
    input  logic       pend_valid,
    input  inst_addr_t pend_addr,
`ifdef BRANCH_PRED_EN
    input  logic       pred_flag,
    input  inst_addr_t pred_addr,
`endif
    output inst_addr_t next_pc,
    output logic       load_pend,
    output logic       clear_pend
);

    inst_addr_t sel;

    always_comb begin
        sel        = pc;
        load_pend  = 1'b0;
        clear_pend = 1'b0;
        if (flush) begin
            sel        = new_pc;
            clear_pend = 1'b1;
        end else if (branch_flag) begin
            // A frozen PC parks the EX target; a newer one overwrites it.
            if (adv) begin
                sel        = branch_target;
                clear_pend = 1'b1;
            end else begin
                load_pend  = 1'b1;
            end
        end else if (adv && pend_valid) begin
            sel        = pend_addr;
            clear_pend = 1'b1;
`ifdef BRANCH_PRED_EN
        end else if (adv && pred_flag) begin
            sel        = pred_addr;
`endif
        end else if (adv) begin
            sel        = pc + PcIncr;
        end
        next_pc = align_pc(sel);
    end

endmodule

// File: rtl/pc_reg_fetch.sv
// PC register, fetch FSM and pending-redirect register.
// Optional static prediction redirect enabled by defining BRANCH_PRED_EN.
module pc_reg_fetch
    import pc_reg_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        branch_flag_pred,
    input  logic [31:0] branch_tar_addr_pred,
    input  logic        inst_ready_i,
    output logic [31:0] pc,
    output logic        ce,
    output logic        stallreq_if_o
);

    fetch_state_e state;
    logic         pend_valid;
    inst_addr_t   pend_addr;
    inst_addr_t   next_pc;
    logic         load_pend;
    logic         clear_pend;
    logic         adv;

    // Only stall[0] belongs to this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

`ifndef BRANCH_PRED_EN
    logic unused_pred;
    assign unused_pred = ^{branch_flag_pred, branch_tar_addr_pred};
`endif

    assign adv           = (state != S_RST) && inst_ready_i && !stall[0];
    assign stallreq_if_o = ce & ~inst_ready_i;

    pc_next_sel u_sel (
        .pc            (pc),
        .adv           (adv),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag_i),
        .branch_target (branch_target_address_i),
        .pend_valid    (pend_valid),
        .pend_addr     (pend_addr),
`ifdef BRANCH_PRED_EN
        .pred_flag     (branch_flag_pred),
        .pred_addr     (branch_tar_addr_pred),
`endif
        .next_pc       (next_pc),
        .load_pend     (load_pend),
        .clear_pend    (clear_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RST;
            pc         <= align_pc(RESET_PC);
            ce         <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= ZeroWord;
        end else begin
            case (state)
                S_RST:   state <= S_RUN;
                S_RUN:   if (!inst_ready_i) state <= S_WAIT;
                S_WAIT:  if (inst_ready_i)  state <= S_RUN;
                default: state <= S_RST;
            endcase
            ce <= 1'b1;
            pc <= next_pc;
            if (load_pend) begin
                pend_valid <= 1'b1;
                pend_addr  <= branch_target_address_i;
            end else if (clear_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_reg_fetch.sv
// Directed and randomized bench for pc_reg_fetch against a behavioural model.
module tb_pc_reg_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        branch_flag_pred;
    logic [31:0] branch_tar_addr_pred;
    logic        inst_ready_i;
    logic [31:0] pc;
    logic        ce;
    logic        stallreq_if_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: fetch address, whether fetching is live, and a parked redirect.
    logic [31:0] m_pc;
    bit          m_live;
    bit          m_pv;
    logic [31:0] m_pa;

`ifdef BRANCH_PRED_EN
    localparam bit PRED_ON = 1'b1;
`else
    localparam bit PRED_ON = 1'b0;
`endif

    pc_reg_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .branch_flag_pred(branch_flag_pred),
        .branch_tar_addr_pred(branch_tar_addr_pred),
        .inst_ready_i(inst_ready_i), .pc(pc), .ce(ce),
        .stallreq_if_o(stallreq_if_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit          go;
        logic [31:0] nxt;
        go = m_live && inst_ready_i && !stall[0];
        if (rst) begin
            m_pc = RST_PC & ~32'd3; m_live = 0; m_pv = 0; m_pa = 0;
        end else begin
            nxt = m_pc;
            if (flush) begin
                nxt = new_pc; m_pv = 0;
            end else if (branch_flag_i && go) begin
                nxt = branch_target_address_i; m_pv = 0;
            end else if (branch_flag_i) begin
                m_pv = 1; m_pa = branch_target_address_i;
            end else if (go && m_pv) begin
                nxt = m_pa; m_pv = 0;
            end else if (go && PRED_ON && branch_flag_pred) begin
                nxt = branch_tar_addr_pred;
            end else if (go) begin
                nxt = m_pc + 32'd4;
            end
            m_pc = nxt & ~32'd3;
            m_live = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; new_pc = 0;
        branch_flag_i = 0; branch_target_address_i = 0;
        branch_flag_pred = 0; branch_tar_addr_pred = 0; inst_ready_i = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("model_pc", pc, m_pc);
                    chk("model_ce", {31'd0, ce}, {31'd0, m_live});
                    chk("model_stallreq", {31'd0, stallreq_if_o},
                        {31'd0, m_live & ~inst_ready_i});
                end
            end
        join_none

        tick(); chk_en = 1; tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_if_o}, 32'd0);
        rst = 0;
        tick(); chk("boot_ce", {31'd0, ce}, 32'd1); chk("boot_pc", pc, 32'h0);
        tick(); chk("run_pc4", pc, 32'h4);
        tick(); chk("run_pc8", pc, 32'h8);
        tick(); chk("run_pc12", pc, 32'hC);
        tick(); chk("run_pc16", pc, 32'h10);

        // EX redirect during a 3-cycle freeze is replayed afterwards.
        stall = 6'b000001;
        tick(); chk("stall_hold1", pc, 32'h10);
        branch_flag_i = 1; branch_target_address_i = 32'h200;
        tick(); chk("stall_hold2", pc, 32'h10);
        branch_flag_i = 0;
        tick(); chk("stall_hold3", pc, 32'h10);
        stall = 0;
        tick(); chk("pend_replay", pc, 32'h200);
        tick(); chk("pend_after", pc, 32'h204);

        flush = 1; new_pc = 32'h20;
        tick(); flush = 0; chk("flush_20", pc, 32'h20);
        branch_flag_pred = 1; branch_tar_addr_pred = 32'h40;
        tick(); branch_flag_pred = 0;
        chk("pred", pc, PRED_ON ? 32'h40 : 32'h24);

        // Flush beats a simultaneous EX redirect and discards it.
        flush = 1; new_pc = 32'h80; branch_flag_i = 1;
        branch_target_address_i = 32'h300; stall = 6'b000001;
        tick(); flush = 0; branch_flag_i = 0; chk("flush_win", pc, 32'h80);
        tick(); chk("flush_hold", pc, 32'h80);
        stall = 0;
        tick(); chk("no_stale_jump", pc, 32'h84);

        flush = 1; new_pc = 32'h8;
        tick(); flush = 0; chk("flush_8", pc, 32'h8);
        inst_ready_i = 0; #1;
        chk("stallreq_c1", {31'd0, stallreq_if_o}, 32'd1);
        tick(); chk("wait_hold1", pc, 32'h8);
        chk("stallreq_c2", {31'd0, stallreq_if_o}, 32'd1);
        tick(); chk("wait_hold2", pc, 32'h8);
        inst_ready_i = 1; #1;
        chk("stallreq_clr", {31'd0, stallreq_if_o}, 32'd0);
        tick(); chk("wait_resume", pc, 32'hC);

        flush = 1; new_pc = 32'hFFFF_FFFC;
        tick(); flush = 0; chk("top_addr", pc, 32'hFFFF_FFFC);
        tick(); chk("wrap", pc, 32'h0);
        branch_flag_i = 1; branch_target_address_i = 32'h103;
        tick(); branch_flag_i = 0; chk("align", pc, 32'h100);

        for (int i = 0; i < 4000; i++) begin
            rst                     = ($urandom_range(63) == 0);
            stall                   = 6'($urandom) & {5'h1F, ($urandom_range(3) == 0)};
            flush                   = ($urandom_range(15) == 0);
            new_pc                  = $urandom;
            branch_flag_i           = ($urandom_range(7) == 0);
            branch_target_address_i = $urandom;
            branch_flag_pred        = ($urandom_range(5) == 0);
            branch_tar_addr_pred    = $urandom;
            inst_ready_i            = ($urandom_range(3) != 0);
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
